// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: I-cache, D-cache and memory port signals shared by the arbiter
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic                  i_write;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_wdata;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  modport master (
    output i_read, i_write, i_address, i_wdata, input i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata, input d_rdata, d_resp,
    input pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
  modport slave (
    input i_read, i_write, i_address, i_wdata, output i_rdata, i_resp,
    input d_read, d_write, d_address, d_wdata, output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one memory port between I-cache and D-cache
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input logic           clk,
  input logic           rst,
  cache_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t                r_state;
  state_t                w_next;
  logic                  r_last;
  logic                  w_next_last;
  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_own_i;
  logic                  w_own_d;
  logic                  w_act_i;
  logic                  w_act_d;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [LINE_WIDTH-1:0] w_wdata;
  assign w_i_req = bus.i_read | bus.i_write;
  assign w_d_req = bus.d_read | bus.d_write;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_last  <= w_next_last;
    end
  end
  // r_last names the previous owner, so a tie goes to the other cache
  always_comb begin
    w_next      = r_state;
    w_next_last = r_last;
    case (r_state)
      IDLE:    w_next = (w_i_req && (!w_d_req || r_last)) ? GRANT_I : (w_d_req ? GRANT_D : IDLE);
      GRANT_I: begin
        if (bus.pmem_resp) begin
          w_next      = IDLE;
          w_next_last = 1'b0;
        end else if (!w_i_req) w_next = IDLE;
      end
      GRANT_D: begin
        if (bus.pmem_resp) begin
          w_next      = IDLE;
          w_next_last = 1'b1;
        end else if (!w_d_req) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  assign w_own_i = r_state == GRANT_I;
  assign w_own_d = r_state == GRANT_D;
  // an owner that has dropped its request drives nothing to memory
  assign w_act_i = w_own_i & w_i_req;
  assign w_act_d = w_own_d & w_d_req;
  assign w_addr  = w_act_i ? bus.i_address : (w_act_d ? bus.d_address : '0);
  assign w_wdata = w_act_i ? bus.i_wdata : (w_act_d ? bus.d_wdata : '0);
  assign bus.pmem_read    = (w_own_i & bus.i_read) | (w_own_d & bus.d_read);
  assign bus.pmem_write   = (w_own_i & bus.i_write) | (w_own_d & bus.d_write);
  assign bus.pmem_address = w_addr;
  assign bus.pmem_wdata   = w_wdata;
  assign bus.i_resp       = w_own_i & bus.pmem_resp;
  assign bus.d_resp       = w_own_d & bus.pmem_resp;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed table plus randomized traffic against an ownership model
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [AW-1:0] IA = 32'h0000_1040;
  localparam logic [AW-1:0] DA = 32'h0000_2000;
  localparam logic [LW-1:0] PA = {8{32'hA5A5_0001}};
  localparam logic [LW-1:0] WI = {8{32'h1111_2222}};
  localparam logic [LW-1:0] PB = {8{32'hBBBB_0000}};
  typedef struct {
    logic rst, ir, iw, dr, dw, pr;
    logic erd, ewr, eir, edr;
    int   sel;
  } row_t;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   m_own;
  bit   m_last;
  row_t tbl[$];
  always #5 clk = ~clk;
  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus();
  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  task automatic chk(string n, logic [LW-1:0] a, logic [LW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  task automatic check_all(string t, logic erd, logic ewr, logic eir, logic edr,
                           logic [AW-1:0] ea, logic [LW-1:0] ew, logic [LW-1:0] er);
    chk({t, " pmem_read"}, LW'(bus.pmem_read), LW'(erd));
    chk({t, " pmem_write"}, LW'(bus.pmem_write), LW'(ewr));
    chk({t, " i_resp"}, LW'(bus.i_resp), LW'(eir));
    chk({t, " d_resp"}, LW'(bus.d_resp), LW'(edr));
    chk({t, " pmem_address"}, LW'(bus.pmem_address), LW'(ea));
    chk({t, " pmem_wdata"}, bus.pmem_wdata, ew);
    chk({t, " i_rdata"}, bus.i_rdata, er);
    chk({t, " d_rdata"}, bus.d_rdata, er);
  endtask
  // who owns the memory port, derived from the arbitration rules
  task automatic model_step();
    logic iq, dq;
    iq = bus.i_read | bus.i_write;
    dq = bus.d_read | bus.d_write;
    if (rst) begin
      m_own  = 0;
      m_last = 1'b1;
    end else if (m_own == 0) begin
      if (iq && dq) m_own = m_last ? 1 : 2;
      else if (iq) m_own = 1;
      else if (dq) m_own = 2;
    end else if (bus.pmem_resp) begin
      m_last = (m_own == 2);
      m_own  = 0;
    end else if (m_own == 1 ? !iq : !dq) m_own = 0;
  endtask
  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask
  function automatic void add(logic r, logic ir, logic iw, logic dr, logic dw, logic pr,
                              logic erd, logic ewr, logic eir, logic edr, int sel);
    row_t x;
    x = '{r, ir, iw, dr, dw, pr, erd, ewr, eir, edr, sel};
    tbl.push_back(x);
  endfunction
  initial begin
    bit ib, db, iseen, dseen;
    logic iq, dq, erd, ewr;
    logic [AW-1:0] ea;
    logic [LW-1:0] ew;
    add(0,1,0,0,0,0, 0,0,0,0,0);
    add(0,1,0,0,0,0, 1,0,0,0,1);
    add(0,1,0,0,0,0, 1,0,0,0,1);
    add(0,1,0,0,0,0, 1,0,0,0,1);
    add(0,1,0,0,0,1, 1,0,1,0,1);
    add(0,1,0,1,0,0, 0,0,0,0,0);
    add(0,1,0,1,0,0, 1,0,0,0,2);
    add(0,1,0,1,0,1, 1,0,0,1,2);
    add(0,1,0,1,0,0, 0,0,0,0,0);
    add(0,1,0,1,0,1, 1,0,1,0,1);
    add(0,1,0,1,0,0, 0,0,0,0,0);
    add(0,1,0,0,1,0, 0,1,0,0,2);
    add(0,1,0,0,1,1, 0,1,0,1,2);
    add(0,1,0,1,0,0, 0,0,0,0,0);
    add(0,1,0,1,0,1, 1,0,1,0,1);
    add(0,1,0,1,0,0, 0,0,0,0,0);
    add(0,1,0,1,0,1, 1,0,0,1,2);
    add(0,0,0,0,0,1, 0,0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0,0);
    add(0,1,0,0,0,1, 1,0,1,0,1);
    add(0,1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0);
    add(0,1,0,1,0,0, 0,0,0,0,0);
    add(0,1,0,1,0,0, 1,0,0,0,2);
    add(1,1,0,1,0,0, 1,0,0,0,2);
    add(0,0,0,0,0,1, 0,0,0,0,0);
    add(0,1,0,1,0,0, 0,0,0,0,0);
    add(0,1,0,1,0,0, 1,0,0,0,1);
    m_own = 0;
    m_last = 1'b1;
    rst = 1'b1;
    bus.i_read = 0; bus.i_write = 0; bus.i_address = IA; bus.i_wdata = WI;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = DA; bus.d_wdata = PB;
    bus.pmem_rdata = PA; bus.pmem_resp = 0;
    advance();
    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst;
      bus.i_read = tbl[k].ir; bus.i_write = tbl[k].iw;
      bus.d_read = tbl[k].dr; bus.d_write = tbl[k].dw;
      bus.pmem_resp = tbl[k].pr;
      #3;
      check_all($sformatf("row%0d", k), tbl[k].erd, tbl[k].ewr, tbl[k].eir, tbl[k].edr,
                tbl[k].sel == 1 ? IA : (tbl[k].sel == 2 ? DA : '0),
                tbl[k].sel == 1 ? WI : (tbl[k].sel == 2 ? PB : '0), PA);
      advance();
    end
    ib = 0; db = 0; iseen = 0; dseen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (iseen) begin ib = 0; bus.i_read = 0; bus.i_write = 0; end
      if (dseen) begin db = 0; bus.d_read = 0; bus.d_write = 0; end
      if (!ib && $urandom_range(0, 2) == 0) begin
        ib = 1;
        bus.i_read = $urandom_range(0, 1);
        bus.i_write = !bus.i_read;
        bus.i_address = $urandom;
        bus.i_wdata = {8{$urandom}};
      end else if (ib && $urandom_range(0, 29) == 0) begin
        ib = 0; bus.i_read = 0; bus.i_write = 0;
      end
      if (!db && $urandom_range(0, 2) == 0) begin
        db = 1;
        bus.d_read = $urandom_range(0, 1);
        bus.d_write = !bus.d_read;
        bus.d_address = $urandom;
        bus.d_wdata = {8{$urandom}};
      end else if (db && $urandom_range(0, 29) == 0) begin
        db = 0; bus.d_read = 0; bus.d_write = 0;
      end
      bus.pmem_resp = $urandom_range(0, 3) == 0;
      bus.pmem_rdata = {8{$urandom}};
      rst = $urandom_range(0, 199) == 0;
      iq = bus.i_read | bus.i_write;
      dq = bus.d_read | bus.d_write;
      erd = m_own == 1 ? bus.i_read : (m_own == 2 ? bus.d_read : 1'b0);
      ewr = m_own == 1 ? bus.i_write : (m_own == 2 ? bus.d_write : 1'b0);
      ea = (m_own == 1 && iq) ? bus.i_address : ((m_own == 2 && dq) ? bus.d_address : '0);
      ew = (m_own == 1 && iq) ? bus.i_wdata : ((m_own == 2 && dq) ? bus.d_wdata : '0);
      #3;
      check_all("rand", erd, ewr, m_own == 1 && bus.pmem_resp, m_own == 2 && bus.pmem_resp,
                ea, ew, bus.pmem_rdata);
      iseen = bus.i_resp === 1'b1;
      dseen = bus.d_resp === 1'b1;
      advance();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
